reg_native_fwd_slice: RTL



---
 rtl/reg_native_fwd_slice.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/reg_native_fwd_slice.sv
// Registered reg_native_if forwarding slice: one outstanding request, downstream ack
// timeout with an error response, global soft-reset re-timing and protocol-violation flags.
module reg_native_fwd_slice #(
    parameter int          ADDR_WIDTH     = 64,
    parameter int          DATA_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                  fsm_clk,
    input  logic                  fsm_rst,
    input  logic                  up_req_vld,
    input  logic                  up_wr_en,
    input  logic                  up_rd_en,
    input  logic [ADDR_WIDTH-1:0] up_addr,
    input  logic [DATA_WIDTH-1:0] up_wr_data,
    output logic                  up_ack_vld,
    output logic [DATA_WIDTH-1:0] up_rd_data,
    output logic                  dn_req_vld,
    output logic                  dn_wr_en,
    output logic                  dn_rd_en,
    output logic [ADDR_WIDTH-1:0] dn_addr,
    output logic [DATA_WIDTH-1:0] dn_wr_data,
    input  logic                  dn_ack_vld,
    input  logic [DATA_WIDTH-1:0] dn_rd_data,
    input  logic                  global_sync_reset_in,
    output logic                  global_sync_reset_out,
    output logic                  err_timeout,
    output logic                  err_illegal,
    output logic                  err_busy,
    output logic                  err_stray
);
    localparam int                    CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(ERR_DATA);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic                    illegal, illegal_nx;
    logic                    up_ack_nx, dn_req_nx, dn_wr_en_nx, dn_rd_en_nx;
    logic [ADDR_WIDTH-1:0]   dn_addr_nx;
    logic [DATA_WIDTH-1:0]   dn_wr_data_nx, up_rd_data_nx;
    logic                    err_timeout_nx, err_illegal_nx, err_busy_nx, err_stray_nx;

    always_comb begin
        // NOTE: every signal gets its default first, so no path can leave one unassigned and infer a latch.
        state_nx       = state;
        cnt_nx         = cnt;
        illegal_nx     = illegal;
        dn_wr_en_nx    = dn_wr_en;
        dn_rd_en_nx    = dn_rd_en;
        dn_addr_nx     = dn_addr;
        dn_wr_data_nx  = dn_wr_data;
        up_rd_data_nx  = up_rd_data;
        up_ack_nx      = 1'b0;
        dn_req_nx      = 1'b0;
        err_timeout_nx = 1'b0;
        err_illegal_nx = 1'b0;
        err_busy_nx    = 1'b0;
        err_stray_nx   = 1'b0;

        if (global_sync_reset_in) begin
            // Soft reset abandons the transaction silently and masks this cycle's request.
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            err_busy_nx  = up_req_vld && (state != IDLE);
            err_stray_nx = dn_ack_vld && (state != WAIT);
            case (state)
                IDLE: begin
                    if (up_req_vld) begin
                        state_nx   = ISSUE;
                        illegal_nx = ~(up_wr_en ^ up_rd_en);
                        if (up_wr_en ^ up_rd_en) begin
                            dn_req_nx     = 1'b1;
                            dn_wr_en_nx   = up_wr_en;
                            dn_rd_en_nx   = up_rd_en;
                            dn_addr_nx    = up_addr;
                            dn_wr_data_nx = up_wr_data;
                        end
                    end
                end
                ISSUE: begin
                    // An illegal request spends its issue slot without going downstream.
                    cnt_nx = '0;
                    if (illegal) begin
                        state_nx       = RESP;
                        up_ack_nx      = 1'b1;
                        up_rd_data_nx  = ERR_WORD;
                        err_illegal_nx = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
                WAIT: begin
                    if (dn_ack_vld) begin
                        state_nx      = RESP;
                        up_ack_nx     = 1'b1;
                        up_rd_data_nx = dn_rd_en ? dn_rd_data : '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nx       = RESP;
                        up_ack_nx      = 1'b1;
                        up_rd_data_nx  = ERR_WORD;
                        err_timeout_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                RESP:    state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge fsm_clk or posedge fsm_rst) begin
        if (fsm_rst) begin
            state                 <= IDLE;
            cnt                   <= '0;
            illegal               <= 1'b0;
            up_ack_vld            <= 1'b0;
            up_rd_data            <= '0;
            dn_req_vld            <= 1'b0;
            dn_wr_en              <= 1'b0;
            dn_rd_en              <= 1'b0;
            dn_addr               <= '0;
            dn_wr_data            <= '0;
            global_sync_reset_out <= 1'b0;
            err_timeout           <= 1'b0;
            err_illegal           <= 1'b0;
            err_busy              <= 1'b0;
            err_stray             <= 1'b0;
        end else begin
            state                 <= state_nx;
            cnt                   <= cnt_nx;
            illegal               <= illegal_nx;
            up_ack_vld            <= up_ack_nx;
            up_rd_data            <= up_rd_data_nx;
            dn_req_vld            <= dn_req_nx;
            dn_wr_en              <= dn_wr_en_nx;
            dn_rd_en              <= dn_rd_en_nx;
            dn_addr               <= dn_addr_nx;
            dn_wr_data            <= dn_wr_data_nx;
            global_sync_reset_out <= global_sync_reset_in;
            err_timeout           <= err_timeout_nx;
            err_illegal           <= err_illegal_nx;
            err_busy              <= err_busy_nx;
            err_stray             <= err_stray_nx;
        end
    end
endmodule
